// File: rtl/serial_frame_tx.sv
// serial_frame_tx: Moore serial frame transmitter.
// Frame on dout: idle-high line, 0-1-1 preamble, payload MSB first,
// optional even-parity bit, then GAP_CYCLES forced idle-high cycles.
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN (adds the PAR state
// and the latched parity bit; undefined by default).
// Reset is asynchronous and active-low; every output is decoded from
// registered state only, so no input reaches an output combinationally.

module serial_frame_tx #(
  parameter int WIDTH      = 8,   // payload bits per frame, 2..32
  parameter int GAP_CYCLES = 2    // idle cycles after each frame, 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  // Bit counter must hold 0..WIDTH.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    LAST_GAP = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE0 = 3'd1,
    PRE1 = 3'd2,
    PRE2 = 3'd3,
    DATA = 3'd4,
`ifdef SERIAL_FRAME_TX_PARITY_EN
    PAR  = 3'd5,
`endif
    GAP  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [3:0]       gapcnt_q, gapcnt_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // State, shift register and counters; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic plus Moore output decode from the registers above.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    parity_d = parity_q;
`endif
    dout  = 1'b1;
    ready = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        // The word and its parity are captured here, so later din
        // changes cannot disturb the frame in flight.
        if (load) begin
          state_d = PRE0;
          shreg_d = din;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          parity_d = ^din;
`endif
        end
      end

      PRE0: begin
        dout    = 1'b0;
        state_d = PRE1;
      end

      PRE1: begin
        state_d = PRE2;
      end

      PRE2: begin
        state_d  = DATA;
        bitcnt_d = '0;
      end

      DATA: begin
        dout     = shreg_q[WIDTH-1];
        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q + CW'(1);
        if (bitcnt_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_d = PAR;
`else
          state_d  = GAP;
          gapcnt_d = '0;
`endif
        end
      end

`ifdef SERIAL_FRAME_TX_PARITY_EN
      PAR: begin
        dout     = parity_q;
        state_d  = GAP;
        gapcnt_d = '0;
      end
`endif

      GAP: begin
        // done marks the first gap cycle only.
        done     = (gapcnt_q == 4'd0);
        gapcnt_d = gapcnt_q + 4'd1;
        if (gapcnt_q == LAST_GAP) begin
          state_d = IDLE;
        end
      end

      default: begin
        // Unreachable encodings recover to IDLE on the next edge.
        state_d = IDLE;
      end
    endcase
  end

endmodule
